rename_regfile: RTL

- Architectural register file plus register alias table (RAT). Sits between decode/dispatch and the reservation stations, and is the consumer of the ROB commit port.
- Each cycle it renames up to 4 new instructions (slots 0..3), allocated at consecutive ROB indices starting at the ROB head.
- For every source operand it returns either a ready 16-bit value or the 4-bit ROB tag of the pending producer.
- Absorbs up to 4 ROB commit writes per cycle and clears all renames on pipeline flush.

---
 rtl/rename_regfile_pkg.sv | 34 +++
 rtl/rename_src_lookup.sv | 76 +++++++
 rtl/rename_regfile.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/rename_regfile_pkg.sv
// Shared rename/commit widths and MSB-first slot (un)flatten helpers.
// Slot 0 occupies the most significant field of every flat bus.
package rename_regfile_pkg;

  localparam int unsigned NUM_SLOTS = 4;
  localparam int unsigned NUM_REGS  = 16;
  localparam int unsigned DATA_W    = 16;
  localparam int unsigned TAG_W     = 4;
  localparam int unsigned REG_W     = 4;

  function automatic int unsigned slot_lsb(input int unsigned slot, input int unsigned width);
    return (NUM_SLOTS - 1 - slot) * width;
  endfunction

  function automatic logic slot_bit(input logic [NUM_SLOTS-1:0] flat, input int unsigned slot);
    return flat[NUM_SLOTS-1-slot];
  endfunction

  function automatic logic [REG_W-1:0] slot_reg(input logic [NUM_SLOTS*REG_W-1:0] flat,
                                                input int unsigned slot);
    return flat[slot_lsb(slot, REG_W) +: REG_W];
  endfunction

  function automatic logic [TAG_W-1:0] slot_tag(input logic [NUM_SLOTS*TAG_W-1:0] flat,
                                                input int unsigned slot);
    return flat[slot_lsb(slot, TAG_W) +: TAG_W];
  endfunction

  function automatic logic [DATA_W-1:0] slot_data(input logic [NUM_SLOTS*DATA_W-1:0] flat,
                                                  input int unsigned slot);
    return flat[slot_lsb(slot, DATA_W) +: DATA_W];
  endfunction

endpackage

// File: rtl/rename_src_lookup.sv
// Resolves one source operand of slot Slot: intra-group forward, commit bypass,
// pending ROB tag, or architectural value.
module rename_src_lookup
  import rename_regfile_pkg::*;
#(
  parameter int unsigned Slot = 0
) (
  input  logic                        slot_valid_i,
  input  logic [REG_W-1:0]            src_i,
  input  logic [TAG_W-1:0]            alloc_head_i,
  input  logic [NUM_SLOTS-1:0]        rename_valid_i,
  input  logic [NUM_SLOTS-1:0]        rename_has_dest_i,
  input  logic [NUM_SLOTS*REG_W-1:0]  rename_dest_i,
  input  logic                        busy_i,
  input  logic [TAG_W-1:0]            tag_i,
  input  logic [DATA_W-1:0]           value_i,
  input  logic [NUM_SLOTS-1:0]        commit_we_i,
  input  logic [NUM_SLOTS*REG_W-1:0]  commit_target_i,
  input  logic [NUM_SLOTS*DATA_W-1:0] commit_data_i,
  input  logic [NUM_SLOTS*TAG_W-1:0]  commit_writer_i,
  output logic                        ready_o,
  output logic [DATA_W-1:0]           value_o,
  output logic [TAG_W-1:0]            tag_o
);

  logic              fwd_hit;
  logic [TAG_W-1:0]  fwd_tag;
  logic              byp_hit;
  logic [DATA_W-1:0] byp_data;

  // Slots at or after this one never forward to it, so some bits go unread.
  logic unused_later_slots;
  assign unused_later_slots = ^{rename_valid_i, rename_has_dest_i, rename_dest_i};

  always_comb begin
    fwd_hit  = 1'b0;
    fwd_tag  = '0;
    byp_hit  = 1'b0;
    byp_data = '0;
    // Ascending scan so the nearest earlier producer wins.
    for (int j = 0; j < int'(Slot); j++) begin
      if (slot_bit(rename_valid_i, j) && slot_bit(rename_has_dest_i, j) &&
          slot_reg(rename_dest_i, j) == src_i) begin
        fwd_hit = 1'b1;
        fwd_tag = alloc_head_i + TAG_W'(j);
      end
    end
    for (int k = 0; k < int'(NUM_SLOTS); k++) begin
      if (slot_bit(commit_we_i, k) && slot_reg(commit_target_i, k) == src_i &&
          slot_tag(commit_writer_i, k) == tag_i) begin
        byp_hit  = 1'b1;
        byp_data = slot_data(commit_data_i, k);
      end
    end

    ready_o = 1'b0;
    value_o = '0;
    tag_o   = '0;
    if (slot_valid_i) begin
      if (src_i == '0) begin
        ready_o = 1'b1;
      end else if (fwd_hit) begin
        tag_o = fwd_tag;
      end else if (busy_i && byp_hit) begin
        ready_o = 1'b1;
        value_o = byp_data;
      end else if (busy_i) begin
        tag_o = tag_i;
      end else begin
        ready_o = 1'b1;
        value_o = value_i;
      end
    end
  end

endmodule

// File: rtl/rename_regfile.sv
// Architectural register file plus RAT: renames up to four instructions per cycle
// and absorbs up to four ROB commits; all lookup results are registered.
module rename_regfile
  import rename_regfile_pkg::*;
(
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_SLOTS-1:0]        rename_valid_flat,
  input  logic [NUM_SLOTS-1:0]        rename_has_dest_flat,
  input  logic [NUM_SLOTS*REG_W-1:0]  rename_dest_flat,
  input  logic [NUM_SLOTS*REG_W-1:0]  rename_src_a_flat,
  input  logic [NUM_SLOTS*REG_W-1:0]  rename_src_b_flat,
  input  logic [TAG_W-1:0]            alloc_head,
  input  logic [NUM_SLOTS-1:0]        commit_we_flat,
  input  logic [NUM_SLOTS*REG_W-1:0]  commit_target_flat,
  input  logic [NUM_SLOTS*DATA_W-1:0] commit_data_flat,
  input  logic [NUM_SLOTS*TAG_W-1:0]  commit_writer_flat,
  input  logic                        flush,
  output logic [NUM_SLOTS-1:0]        out_valid_flat,
  output logic [NUM_SLOTS-1:0]        src_a_ready_flat,
  output logic [NUM_SLOTS-1:0]        src_b_ready_flat,
  output logic [NUM_SLOTS*DATA_W-1:0] src_a_value_flat,
  output logic [NUM_SLOTS*DATA_W-1:0] src_b_value_flat,
  output logic [NUM_SLOTS*TAG_W-1:0]  src_a_tag_flat,
  output logic [NUM_SLOTS*TAG_W-1:0]  src_b_tag_flat
);

  logic [NUM_REGS-1:0][DATA_W-1:0] value_q, value_d;
  logic [NUM_REGS-1:0]             busy_q, busy_d;
  logic [NUM_REGS-1:0][TAG_W-1:0]  tag_q, tag_d;

  logic [NUM_SLOTS-1:0]        a_ready_d, b_ready_d, a_ready_q, b_ready_q, out_valid_q;
  logic [NUM_SLOTS*DATA_W-1:0] a_value_d, b_value_d, a_value_q, b_value_q;
  logic [NUM_SLOTS*TAG_W-1:0]  a_tag_d, b_tag_d, a_tag_q, b_tag_q;

  for (genvar s = 0; s < NUM_SLOTS; s++) begin : g_slot
    logic [REG_W-1:0] src_a, src_b;
    assign src_a = slot_reg(rename_src_a_flat, s);
    assign src_b = slot_reg(rename_src_b_flat, s);

    rename_src_lookup #(.Slot(s)) u_lookup_a (
      .slot_valid_i      (rename_valid_flat[NUM_SLOTS-1-s]),
      .src_i             (src_a),
      .alloc_head_i      (alloc_head),
      .rename_valid_i    (rename_valid_flat),
      .rename_has_dest_i (rename_has_dest_flat),
      .rename_dest_i     (rename_dest_flat),
      .busy_i            (busy_q[src_a]),
      .tag_i             (tag_q[src_a]),
      .value_i           (value_q[src_a]),
      .commit_we_i       (commit_we_flat),
      .commit_target_i   (commit_target_flat),
      .commit_data_i     (commit_data_flat),
      .commit_writer_i   (commit_writer_flat),
      .ready_o           (a_ready_d[NUM_SLOTS-1-s]),
      .value_o           (a_value_d[(NUM_SLOTS-1-s)*DATA_W +: DATA_W]),
      .tag_o             (a_tag_d[(NUM_SLOTS-1-s)*TAG_W +: TAG_W])
    );

    rename_src_lookup #(.Slot(s)) u_lookup_b (
      .slot_valid_i      (rename_valid_flat[NUM_SLOTS-1-s]),
      .src_i             (src_b),
      .alloc_head_i      (alloc_head),
      .rename_valid_i    (rename_valid_flat),
      .rename_has_dest_i (rename_has_dest_flat),
      .rename_dest_i     (rename_dest_flat),
      .busy_i            (busy_q[src_b]),
      .tag_i             (tag_q[src_b]),
      .value_i           (value_q[src_b]),
      .commit_we_i       (commit_we_flat),
      .commit_target_i   (commit_target_flat),
      .commit_data_i     (commit_data_flat),
      .commit_writer_i   (commit_writer_flat),
      .ready_o           (b_ready_d[NUM_SLOTS-1-s]),
      .value_o           (b_value_d[(NUM_SLOTS-1-s)*DATA_W +: DATA_W]),
      .tag_o             (b_tag_d[(NUM_SLOTS-1-s)*TAG_W +: TAG_W])
    );
  end

  logic [REG_W-1:0] c_tgt, r_dst;

  always_comb begin
    value_d = value_q;
    busy_d  = busy_q;
    tag_d   = tag_q;
    c_tgt   = '0;
    r_dst   = '0;
    // Ascending order: the higher commit slot wins a shared target.
    for (int k = 0; k < int'(NUM_SLOTS); k++) begin
      c_tgt = slot_reg(commit_target_flat, k);
      if (slot_bit(commit_we_flat, k) && c_tgt != '0) begin
        value_d[c_tgt] = slot_data(commit_data_flat, k);
        if (tag_q[c_tgt] == slot_tag(commit_writer_flat, k)) begin
          busy_d[c_tgt] = 1'b0;
        end
      end
    end
    // Renames applied after commits so they override a same-cycle busy clear.
    if (flush) begin
      busy_d = '0;
    end else begin
      for (int i = 0; i < int'(NUM_SLOTS); i++) begin
        r_dst = slot_reg(rename_dest_flat, i);
        if (slot_bit(rename_valid_flat, i) && slot_bit(rename_has_dest_flat, i) &&
            r_dst != '0) begin
          busy_d[r_dst] = 1'b1;
          tag_d[r_dst]  = alloc_head + TAG_W'(i);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      value_q     <= '0;
      busy_q      <= '0;
      tag_q       <= '0;
      out_valid_q <= '0;
      a_ready_q   <= '0;
      b_ready_q   <= '0;
      a_value_q   <= '0;
      b_value_q   <= '0;
      a_tag_q     <= '0;
      b_tag_q     <= '0;
    end else begin
      value_q     <= value_d;
      busy_q      <= busy_d;
      tag_q       <= tag_d;
      out_valid_q <= flush ? '0 : rename_valid_flat;
      a_ready_q   <= a_ready_d;
      b_ready_q   <= b_ready_d;
      a_value_q   <= a_value_d;
      b_value_q   <= b_value_d;
      a_tag_q     <= a_tag_d;
      b_tag_q     <= b_tag_d;
    end
  end

  assign out_valid_flat   = out_valid_q;
  assign src_a_ready_flat = a_ready_q;
  assign src_b_ready_flat = b_ready_q;
  assign src_a_value_flat = a_value_q;
  assign src_b_value_flat = b_value_q;
  assign src_a_tag_flat   = a_tag_q;
  assign src_b_tag_flat   = b_tag_q;

endmodule
